accel_line_sender: RTL and testbench

ACCEL_LINE_SENDER -- requirements
Module: accel_line_sender

---
 rtl/accel_line_sender_if.sv | 52 +++++
 rtl/accel_line_sender.sv | 215 +++++++++++++++++++++
 tb/tb_accel_line_sender.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_line_sender_if.sv
// Bundle between the ASCII converter stage and the UART line sender.
// Carries: enable, ready, 16 digit bytes, 4 sign flags in; uart_tx, busy, line_done, overrun out.
interface accel_line_sender_if;
   logic       enable;
   logic       ready;
   logic [7:0] ascii_X1;
   logic [7:0] ascii_X2;
   logic [7:0] ascii_X3;
   logic [7:0] ascii_X4;
   logic [7:0] ascii_Y1;
   logic [7:0] ascii_Y2;
   logic [7:0] ascii_Y3;
   logic [7:0] ascii_Y4;
   logic [7:0] ascii_Z1;
   logic [7:0] ascii_Z2;
   logic [7:0] ascii_Z3;
   logic [7:0] ascii_Z4;
   logic [7:0] ascii_T1;
   logic [7:0] ascii_T2;
   logic [7:0] ascii_T3;
   logic [7:0] ascii_T4;
   logic       is_negative_X;
   logic       is_negative_Y;
   logic       is_negative_Z;
   logic       is_negative_T;
   logic       uart_tx;
   logic       busy;
   logic       line_done;
   logic       overrun;

   modport master (
      output enable, ready,
      output ascii_X1, ascii_X2, ascii_X3, ascii_X4,
      output ascii_Y1, ascii_Y2, ascii_Y3, ascii_Y4,
      output ascii_Z1, ascii_Z2, ascii_Z3, ascii_Z4,
      output ascii_T1, ascii_T2, ascii_T3, ascii_T4,
      output is_negative_X, is_negative_Y,
      output is_negative_Z, is_negative_T,
      input  uart_tx, busy, line_done, overrun
   );

   modport slave (
      input  enable, ready,
      input  ascii_X1, ascii_X2, ascii_X3, ascii_X4,
      input  ascii_Y1, ascii_Y2, ascii_Y3, ascii_Y4,
      input  ascii_Z1, ascii_Z2, ascii_Z3, ascii_Z4,
      input  ascii_T1, ascii_T2, ascii_T3, ascii_T4,
      input  is_negative_X, is_negative_Y,
      input  is_negative_Z, is_negative_T,
      output uart_tx, busy, line_done, overrun
   );
endinterface

// File: rtl/accel_line_sender.sv
// Sends one 33-byte text line "X=sdddd Y=sdddd Z=sdddd T=sdddd\r\n" over 8N1 UART.
// Ports: clk, reset (async, active low), bus (slave: enable/ready/digits/signs in; uart_tx/busy/line_done/overrun out).
module accel_line_sender #(
   parameter int CLKS_PER_BIT = 868
) (
   input logic           clk,
   input logic           reset,
   accel_line_sender_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [5:0]  BYTE_LAST = 6'd32;

   state_t            state_q;
   state_t            state_n;
   logic [5:0]        byte_q;
   logic [5:0]        byte_n;
   logic [2:0]        bit_q;
   logic [2:0]        bit_n;
   logic [2:0]        bit_inc;
   logic [15:0]       baud_q;
   logic [15:0]       baud_n;
   logic              tx_q;
   logic              tx_n;
   logic              busy_q;
   logic              busy_n;
   logic              done_q;
   logic              done_n;
   logic              pend_q;
   logic              pend_n;
   logic              ovr_q;
   logic              ovr_n;
   logic              ready_d;
   logic              trig;
   logic              load;
   logic              bit_end;

   // Element 0 holds X1, element 15 holds T4.
   logic [15:0][7:0]  snap_dig;
   logic [15:0][7:0]  dig_in;
   // Bit 0 is X, bit 3 is T.
   logic [3:0]        snap_sgn;
   logic [3:0]        sgn_in;

   logic [1:0]        grp;
   logic [2:0]        ofs;
   logic [3:0]        dig_idx;
   logic [7:0]        cur_byte;

   assign dig_in = {
      bus.ascii_T4, bus.ascii_T3, bus.ascii_T2, bus.ascii_T1,
      bus.ascii_Z4, bus.ascii_Z3, bus.ascii_Z2, bus.ascii_Z1,
      bus.ascii_Y4, bus.ascii_Y3, bus.ascii_Y2, bus.ascii_Y1,
      bus.ascii_X4, bus.ascii_X3, bus.ascii_X2, bus.ascii_X1
   };

   assign sgn_in = {
      bus.is_negative_T, bus.is_negative_Z,
      bus.is_negative_Y, bus.is_negative_X
   };

   assign trig    = bus.enable & bus.ready & ~ready_d;
   assign bit_end = (baud_q == BAUD_LAST);
   assign bit_inc = bit_q + 3'd1;

   // The line is four 8-byte groups ("X=sdddd ", ...) plus a final LF.
   // Offset 7 of the last group carries CR instead of a space.
   assign grp     = byte_q[4:3];
   assign ofs     = byte_q[2:0];
   assign dig_idx = {grp, 2'b00} + {1'b0, ofs} - 4'd3;

   always_comb begin
      cur_byte = 8'h0A;
      if (!byte_q[5]) begin
         case (ofs)
            3'd0: begin
               case (grp)
                  2'd0:    cur_byte = 8'h58;
                  2'd1:    cur_byte = 8'h59;
                  2'd2:    cur_byte = 8'h5A;
                  default: cur_byte = 8'h54;
               endcase
            end
            3'd1: cur_byte = 8'h3D;
            3'd2: cur_byte = snap_sgn[grp] ? 8'h2D : 8'h2B;
            3'd3,
            3'd4,
            3'd5,
            3'd6: cur_byte = snap_dig[dig_idx];
            default: cur_byte = (grp == 2'd3) ? 8'h0D : 8'h20;
         endcase
      end
   end

   always_comb begin
      state_n = state_q;
      byte_n  = byte_q;
      bit_n   = bit_q;
      baud_n  = baud_q;
      tx_n    = tx_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      pend_n  = pend_q;
      ovr_n   = ovr_q;
      load    = 1'b0;

      // One line may queue behind the active one; more are flagged.
      if (trig && state_q != IDLE) begin
         if (pend_q) ovr_n = 1'b1;
         else        pend_n = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (trig || pend_q) begin
               state_n = START;
               load    = 1'b1;
               byte_n  = '0;
               bit_n   = '0;
               baud_n  = '0;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
               // A fresh edge arriving while a queued line launches stays queued.
               pend_n  = pend_q & trig;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
               baud_n  = '0;
               tx_n    = cur_byte[0];
            end else begin
               baud_n = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n = '0;
               if (bit_q == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_inc;
                  tx_n  = cur_byte[bit_inc];
               end
            end else begin
               baud_n = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_n = '0;
               if (byte_q == BYTE_LAST) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  state_n = START;
                  byte_n  = byte_q + 6'd1;
                  tx_n    = 1'b0;
               end
            end else begin
               baud_n = baud_q + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         byte_q   <= '0;
         bit_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
         ready_d  <= 1'b0;
         snap_dig <= '0;
         snap_sgn <= '0;
      end else begin
         state_q <= state_n;
         byte_q  <= byte_n;
         bit_q   <= bit_n;
         baud_q  <= baud_n;
         tx_q    <= tx_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         pend_q  <= pend_n;
         ovr_q   <= ovr_n;
         ready_d <= bus.ready;
         if (load) begin
            snap_dig <= dig_in;
            snap_sgn <= sgn_in;
         end
      end
   end

   assign bus.uart_tx   = tx_q;
   assign bus.busy      = busy_q;
   assign bus.line_done = done_q;
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_accel_line_sender.sv
// Bench for accel_line_sender at CLKS_PER_BIT=4.
// Drives the bus interface and decodes uart_tx against a line model.
module tb_accel_line_sender;

   localparam int CPB  = 4;
   localparam int LINE = 330 * CPB;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   accel_line_sender_if ifc ();

   accel_line_sender #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [263:0] obs,
                      input logic [263:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Digits are a 16-char string, X1 first; signs are {X,Y,Z,T}.
   task automatic set_inputs(input logic [127:0] dv, input logic [3:0] nv);
      ifc.ascii_X1 = dv[127:120];
      ifc.ascii_X2 = dv[119:112];
      ifc.ascii_X3 = dv[111:104];
      ifc.ascii_X4 = dv[103:96];
      ifc.ascii_Y1 = dv[95:88];
      ifc.ascii_Y2 = dv[87:80];
      ifc.ascii_Y3 = dv[79:72];
      ifc.ascii_Y4 = dv[71:64];
      ifc.ascii_Z1 = dv[63:56];
      ifc.ascii_Z2 = dv[55:48];
      ifc.ascii_Z3 = dv[47:40];
      ifc.ascii_Z4 = dv[39:32];
      ifc.ascii_T1 = dv[31:24];
      ifc.ascii_T2 = dv[23:16];
      ifc.ascii_T3 = dv[15:8];
      ifc.ascii_T4 = dv[7:0];
      ifc.is_negative_X = nv[3];
      ifc.is_negative_Y = nv[2];
      ifc.is_negative_Z = nv[1];
      ifc.is_negative_T = nv[0];
   endtask

   function automatic logic [127:0] rnd_digits();
      logic [127:0] v;
      for (int i = 0; i < 16; i++)
         v[8*i +: 8] = 8'h30 + 8'($urandom_range(0, 9));
      return v;
   endfunction

   // Expected line as a 33-char string, first char in the top byte.
   function automatic logic [263:0] exp_line(input logic [127:0] dv,
                                              input logic [3:0] nv);
      logic [263:0] v;
      logic [31:0]  names;
      v = '0;
      names = "XYZT";
      for (int g = 0; g < 4; g++) begin
         if (g > 0) v = {v[255:0], 8'h20};
         v = {v[255:0], names[31 - 8*g -: 8]};
         v = {v[255:0], 8'h3D};
         v = {v[255:0], nv[3 - g] ? 8'h2D : 8'h2B};
         for (int k = 0; k < 4; k++)
            v = {v[255:0], dv[127 - 32*g - 8*k -: 8]};
      end
      v = {v[255:0], 8'h0D};
      v = {v[255:0], 8'h0A};
      return v;
   endfunction

   // Serial bit n of the line: 10 bits per byte, start, LSB first, stop.
   function automatic logic fbit(input logic [263:0] v, input int n);
      int i;
      int j;
      i = n / 10;
      j = n % 10;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return v[255 - 8*i + j];
   endfunction

   task automatic rx_line(input logic [263:0] exp, input string tag,
                          output int ts);
      logic [263:0] got;
      logic [7:0]   cur;
      int n;
      int tdone;
      int wbad;
      int bbad;
      int j;
      n  = 0;
      ts = -1;
      while (ifc.uart_tx !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start"}, ifc.uart_tx, 1'b0);
      if (ifc.uart_tx !== 1'b0) return;
      ts    = cyc;
      got   = '0;
      cur   = '0;
      tdone = -1;
      wbad  = 0;
      bbad  = 0;
      for (int r = 0; r <= LINE; r++) begin
         if (r > 0) @(negedge clk);
         if (r < LINE) begin
            if (ifc.uart_tx !== fbit(exp, r / CPB)) wbad++;
            if (ifc.busy !== 1'b1) bbad++;
            j = (r / CPB) % 10;
            if (r % CPB == CPB / 2 && j >= 1 && j <= 8) begin
               cur[j - 1] = ifc.uart_tx;
               if (j == 8) got = {got[255:0], cur};
            end
         end else begin
            if (ifc.uart_tx !== 1'b1) wbad++;
            if (ifc.busy !== 1'b0) bbad++;
         end
         if (ifc.line_done === 1'b1 && tdone < 0) tdone = r;
      end
      chk({tag, "_bytes"}, got, exp);
      chk({tag, "_wave_errs"}, wbad, 0);
      chk({tag, "_busy_errs"}, bbad, 0);
      chk({tag, "_done_at"}, tdone, LINE);
   endtask

   initial begin
      logic [263:0] line0;
      logic [127:0] da;
      logic [127:0] db;
      logic [3:0]   na;
      logic [3:0]   nb;
      logic [263:0] ea;
      logic [263:0] eb;
      int c0;
      int ts1;
      int ts2;
      int viol;

      line0 = {"X=+0123 Y=-0456 Z=+1000 T=+0250", 16'h0D0A};
      reset = 1'b0;
      ifc.enable = 1'b1;
      ifc.ready  = 1'b0;
      set_inputs('0, '0);
      repeat (2) @(negedge clk);
      chk("rst_tx", ifc.uart_tx, 1'b1);
      chk("rst_busy", ifc.busy, 1'b0);
      chk("rst_done", ifc.line_done, 1'b0);
      chk("rst_ovr", ifc.overrun, 1'b0);
      reset = 1'b1;

      // Fixed line, single ready pulse.
      set_inputs("0123045610000250", 4'b0100);
      repeat (3) @(posedge clk);
      #1;
      ifc.ready = 1'b1;
      c0 = cyc;
      fork
         rx_line(line0, "basic", ts1);
         begin
            wait_cyc(c0 + 3);
            ifc.ready = 1'b0;
         end
      join
      chk("basic_ts", ts1, c0 + 1);

      // Inputs change after the trigger; ready stays high throughout.
      da = rnd_digits();
      na = 4'($urandom_range(0, 15));
      db = rnd_digits();
      nb = ~na;
      set_inputs(da, na);
      ea = exp_line(da, na);
      @(posedge clk);
      #1;
      ifc.ready = 1'b1;
      c0 = cyc;
      fork
         rx_line(ea, "snap", ts1);
         begin
            wait_cyc(c0 + 1);
            set_inputs(db, nb);
         end
      join
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.busy !== 1'b0 || ifc.uart_tx !== 1'b1) viol++;
      end
      chk("ready_held_idle", viol, 0);
      ifc.ready = 1'b0;

      // Second edge queues a line, third edge overruns.
      da = rnd_digits();
      na = 4'($urandom_range(0, 15));
      db = rnd_digits();
      nb = 4'($urandom_range(0, 15));
      set_inputs(da, na);
      ea = exp_line(da, na);
      eb = exp_line(db, nb);
      chk("ovr_before", ifc.overrun, 1'b0);
      @(posedge clk);
      #1;
      ifc.ready = 1'b1;
      c0 = cyc;
      fork
         rx_line(ea, "pend_a", ts1);
         begin
            wait_cyc(c0 + 3);
            ifc.ready = 1'b0;
            wait_cyc(c0 + 100);
            ifc.ready = 1'b1;
            wait_cyc(c0 + 103);
            ifc.ready = 1'b0;
            set_inputs(db, nb);
            wait_cyc(c0 + 200);
            ifc.ready = 1'b1;
            wait_cyc(c0 + 203);
            ifc.ready = 1'b0;
         end
      join
      rx_line(eb, "pend_b", ts2);
      chk("pend_gap", ts2 - ts1, LINE + 1);
      chk("ovr_set", ifc.overrun, 1'b1);
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.busy !== 1'b0) viol++;
      end
      chk("one_extra_only", viol, 0);

      // Edge with enable low is ignored.
      ifc.enable = 1'b0;
      ifc.ready  = 1'b1;
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 3) ifc.ready = 1'b0;
         if (ifc.busy !== 1'b0 || ifc.uart_tx !== 1'b1) viol++;
      end
      chk("enable_off", viol, 0);

      // Enable dropped mid-line: line still completes.
      ifc.enable = 1'b1;
      da = rnd_digits();
      na = 4'($urandom_range(0, 15));
      set_inputs(da, na);
      ea = exp_line(da, na);
      @(posedge clk);
      #1;
      ifc.ready = 1'b1;
      c0 = cyc;
      fork
         rx_line(ea, "en_drop", ts1);
         begin
            wait_cyc(c0 + 3);
            ifc.ready = 1'b0;
            wait_cyc(c0 + 60);
            ifc.enable = 1'b0;
         end
      join
      ifc.enable = 1'b1;

      // Reset in byte 10, then a full line after release.
      da = rnd_digits();
      na = 4'($urandom_range(0, 15));
      set_inputs(da, na);
      @(posedge clk);
      #1;
      ifc.ready = 1'b1;
      c0 = cyc;
      wait_cyc(c0 + 1 + 10 * 10 * CPB + 6);
      chk("pre_rst_busy", ifc.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_rst_tx", ifc.uart_tx, 1'b1);
      chk("mid_rst_busy", ifc.busy, 1'b0);
      chk("mid_rst_ovr", ifc.overrun, 1'b0);
      db = rnd_digits();
      nb = 4'($urandom_range(0, 15));
      set_inputs(db, nb);
      eb = exp_line(db, nb);
      repeat (3) @(negedge clk);
      chk("rst_hold_tx", ifc.uart_tx, 1'b1);
      #2;
      reset = 1'b1;
      c0 = cyc;
      rx_line(eb, "rst_new", ts1);
      chk("rst_new_ts", ts1, c0 + 1);
      ifc.ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
